// File: rtl/riscv_defines.sv
// Shared types and constants for the instruction prefetcher.
package riscv_defines;

  // Bus-request FSM: REQ means a request is being driven and has not been granted yet.
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  // Distance between consecutive instruction words.
  localparam logic [31:0] WORD_INCR = 32'd4;

  // One buffered instruction word together with its address and bus-error flag.
  typedef struct packed {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO of fetched words. The head is read straight from the
// storage array, so a word pushed in cycle N is visible at the head in cycle N+1.
module riscv_fetch_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state; flush empties the FIFO in one cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/riscv_fetch_prefetcher.sv
// Instruction prefetcher: issues word fetches on the instruction bus, tracks
// in-flight transactions, drops responses made stale by a branch, and buffers
// the rest for the IF stage.
module riscv_fetch_prefetcher
  import riscv_defines::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        fetch_failed_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      resp_addr_q, resp_addr_d;
  logic [31:0]      target_q, target_d;       // branch target parked behind an ungranted request
  logic             pending_q, pending_d;     // a branch is waiting for the held request's grant
  logic             booted_q, booted_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  fetch_entry_t     fifo_head, fifo_wdata;
  logic [CNT_W:0]   inflight_sum;
  logic             can_req, req_raw, hold, gnt_fire, rvalid_fire, discarding, push, pop;

  assign inflight_sum = {1'b0, out_q} + {1'b0, fifo_count};
  assign can_req = booted_q && req_i && !branch_i
                && (inflight_sum < (CNT_W+1)'(FIFO_DEPTH))
                && (out_q < CNT_W'(MAX_OUTSTANDING));

  // Request FSM: a new request starts whenever the request rule holds; once
  // driven without a grant it is held (address included) until granted.
  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_raw = can_req;
        if (can_req && !instr_gnt_i) state_d = REQ;
      end
      REQ: begin
        req_raw = 1'b1;
        if (instr_gnt_i) state_d = IDLE;
      end
    endcase
  end

  assign instr_req_o  = req_raw && !rst;
  assign instr_addr_o = fetch_addr_q;
  assign hold         = instr_req_o && !instr_gnt_i;
  assign gnt_fire     = instr_req_o && instr_gnt_i;
  assign rvalid_fire  = instr_rvalid_i && (out_q != '0);
  assign discarding   = (discard_q != '0);
  assign push         = rvalid_fire && !discarding && !branch_i;
  assign pop          = valid_o && ready_i;

  // Address, outstanding and discard bookkeeping.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_addr_d  = resp_addr_q;
    target_d     = target_q;
    pending_d    = pending_q;
    booted_d     = booted_q || branch_i;
    out_d        = out_q + CNT_W'(gnt_fire) - CNT_W'(rvalid_fire);
    discard_d    = discard_q;

    if (branch_i && hold) begin
      // The bus still owns the old address; redirect once it is granted.
      target_d  = word_align(branch_addr_i);
      pending_d = 1'b1;
    end else if (branch_i) begin
      fetch_addr_d = word_align(branch_addr_i);
      pending_d    = 1'b0;
    end else if (gnt_fire) begin
      fetch_addr_d = pending_q ? target_q : fetch_addr_q + WORD_INCR;
      pending_d    = 1'b0;
    end

    if (branch_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d = out_d;
    end else begin
      if (rvalid_fire && discarding) discard_d = discard_d - 1'b1;
      if (gnt_fire && pending_q)     discard_d = discard_d + 1'b1;
    end

    if (branch_i)  resp_addr_d = word_align(branch_addr_i);
    else if (push) resp_addr_d = resp_addr_q + WORD_INCR;
  end

  // State registers; reset clears all tracking and waits for a boot branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      resp_addr_q  <= '0;
      target_q     <= '0;
      pending_q    <= 1'b0;
      booted_q     <= 1'b0;
      out_q        <= '0;
      discard_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      target_q     <= target_d;
      pending_q    <= pending_d;
      booted_q     <= booted_d;
      out_q        <= out_d;
      discard_q    <= discard_d;
    end
  end

  assign fifo_wdata = '{addr: resp_addr_q, err: instr_err_i, data: instr_rdata_i};

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (branch_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign valid_o        = !fifo_empty && !branch_i && !rst;
  assign rdata_o        = fifo_head.data;
  assign addr_o         = fifo_head.addr;
  assign fetch_failed_o = valid_o && fifo_head.err;
  assign busy_o         = ((out_q != '0) || instr_req_o) && !rst;

endmodule
